// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage owning the stack pointer; sequences
// single-word and two-word stack accesses and registers results for Write-Back.
module memory_stage #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(2**ADDR_W-1),
  parameter int WB_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        m_op,
  input  logic [15:0]       alu_in,
  input  logic [15:0]       rdst_in,
  input  logic [31:0]       pc_in,
  input  logic [WB_W-1:0]   wb_in,
  output logic              stall,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [15:0]       dmem_rdata,
  output logic [15:0]       sp_out,
  output logic              out_valid,
  output logic [15:0]       mem_result,
  output logic [15:0]       alu_out,
  output logic [WB_W-1:0]   wb_out,
  output logic [31:0]       pc_out,
  output logic              pc_valid
);
  typedef enum logic [2:0] {IDLE, A1, A2, RD, DONE} state_t;
  localparam logic [2:0] OP_LD = 3'd1, OP_ST = 3'd2, OP_PUSH = 3'd3, OP_POP = 3'd4,
                         OP_PUSH32 = 3'd5, OP_POP32 = 3'd6;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [15:0] alu_q, alu_d, rdst_q, rdst_d, lo_q, lo_d, mem_result_q, mem_result_d;
  logic [15:0] alu_out_q, alu_out_d, dmem_wdata_q, dmem_wdata_d;
  logic [31:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [WB_W-1:0] wb_q, wb_d, wb_out_q, wb_out_d;
  logic [ADDR_W-1:0] sp_q, sp_d, dmem_addr_q, dmem_addr_d;
  logic stall_q, stall_d, out_valid_q, out_valid_d, pc_valid_q, pc_valid_d;
  logic dmem_we_q, dmem_we_d, dmem_re_q, dmem_re_d;
  logic acc, none, issue, push_like, pop_like, wr, done;
  always_comb begin
    acc = (state_q == IDLE || state_q == DONE) && in_valid;
    op_d = acc ? m_op : op_q;
    alu_d = acc ? alu_in : alu_q;
    rdst_d = acc ? rdst_in : rdst_q;
    pc_d = acc ? pc_in : pc_q;
    wb_d = acc ? wb_in : wb_q;
    lo_d = state_q == A2 ? dmem_rdata : lo_q;
    none = op_d == 3'd0 || op_d == 3'd7;
    unique case (state_q)
      A1: state_d = (op_q == OP_LD || op_q == OP_POP) ? RD :
                    (op_q == OP_PUSH32 || op_q == OP_POP32) ? A2 : DONE;
      A2: state_d = op_q == OP_POP32 ? RD : DONE;
      RD: state_d = DONE;
      default: state_d = acc ? (none ? DONE : A1) : IDLE;
    endcase
    // Commands are registered on the edge entering A1 (from accept) or A2 (from A1)
    issue = (acc && !none) || (state_q == A1 && state_d == A2);
    push_like = op_d == OP_PUSH || op_d == OP_PUSH32;
    pop_like = op_d == OP_POP || op_d == OP_POP32;
    wr = op_d == OP_ST || push_like;
    dmem_we_d = issue && wr;
    dmem_re_d = issue && !wr;
    dmem_addr_d = !issue ? dmem_addr_q : (op_d == OP_LD || op_d == OP_ST) ? alu_d[ADDR_W-1:0] :
                  pop_like ? sp_q + 1'b1 : sp_q;
    dmem_wdata_d = !issue ? dmem_wdata_q : op_d == OP_PUSH32 ? (acc ? pc_d[31:16] : pc_d[15:0]) : rdst_d;
    sp_d = !issue ? sp_q : push_like ? sp_q - 1'b1 : pop_like ? sp_q + 1'b1 : sp_q;
    done = state_d == DONE;
    out_valid_d = done;
    stall_d = state_d == A1 || state_d == A2 || state_d == RD;
    alu_out_d = done ? alu_d : alu_out_q;
    wb_out_d = done ? wb_d : wb_out_q;
    mem_result_d = !done ? mem_result_q : (op_d == OP_LD || op_d == OP_POP) ? dmem_rdata : '0;
    pc_valid_d = done && op_d == OP_POP32;
    pc_out_d = pc_valid_d ? {dmem_rdata, lo_q} : pc_out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      alu_q <= '0;
      rdst_q <= '0;
      pc_q <= '0;
      wb_q <= '0;
      lo_q <= '0;
      sp_q <= SP_INIT;
      dmem_addr_q <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q <= 1'b0;
      dmem_re_q <= 1'b0;
      stall_q <= 1'b0;
      out_valid_q <= 1'b0;
      mem_result_q <= '0;
      alu_out_q <= '0;
      wb_out_q <= '0;
      pc_out_q <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      alu_q <= alu_d;
      rdst_q <= rdst_d;
      pc_q <= pc_d;
      wb_q <= wb_d;
      lo_q <= lo_d;
      sp_q <= sp_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q <= dmem_we_d;
      dmem_re_q <= dmem_re_d;
      stall_q <= stall_d;
      out_valid_q <= out_valid_d;
      mem_result_q <= mem_result_d;
      alu_out_q <= alu_out_d;
      wb_out_q <= wb_out_d;
      pc_out_q <= pc_out_d;
      pc_valid_q <= pc_valid_d;
    end
  end
  assign stall = stall_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_we = dmem_we_q;
  assign dmem_re = dmem_re_q;
  assign sp_out = 16'(sp_q);
  assign out_valid = out_valid_q;
  assign mem_result = mem_result_q;
  assign alu_out = alu_out_q;
  assign wb_out = wb_out_q;
  assign pc_out = pc_out_q;
  assign pc_valid = pc_valid_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random and directed stimulus against a word-level stack/memory model.
module tb_memory_stage;
  logic clk = 0, rst, in_valid, stall, dmem_we, dmem_re, out_valid, pc_valid;
  logic [2:0] m_op;
  logic [15:0] alu_in, rdst_in, wb_in, dmem_wdata, dmem_rdata, sp_out, mem_result, alu_out, wb_out;
  logic [31:0] pc_in, pc_out;
  logic [11:0] dmem_addr;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  int ref_sp, checks = 0, errors = 0;

  memory_stage #(.ADDR_W(12), .WB_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .m_op(m_op), .alu_in(alu_in), .rdst_in(rdst_in),
    .pc_in(pc_in), .wb_in(wb_in), .stall(stall), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata), .sp_out(sp_out),
    .out_valid(out_valid), .mem_result(mem_result), .alu_out(alu_out), .wb_out(wb_out),
    .pc_out(pc_out), .pc_valid(pc_valid));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= mem[dmem_addr];
  end

  // Reference: each op applied atomically to a word array and an integer SP
  task automatic model(input logic [2:0] op, input logic [15:0] a, r, input logic [31:0] p,
                       output logic [15:0] res, output logic [31:0] pco, output logic pcv,
                       output int lat, output int wes);
    res = 0; pco = 0; pcv = 0; lat = 1; wes = 0;
    case (op)
      3'd1: begin res = ref_mem[a[11:0]]; lat = 3; end
      3'd2: begin ref_mem[a[11:0]] = r; lat = 2; wes = 1; end
      3'd3: begin ref_mem[ref_sp] = r; ref_sp = (ref_sp + 4095) % 4096; lat = 2; wes = 1; end
      3'd4: begin ref_sp = (ref_sp + 1) % 4096; res = ref_mem[ref_sp]; lat = 3; end
      3'd5: begin
        ref_mem[ref_sp] = p[31:16]; ref_sp = (ref_sp + 4095) % 4096;
        ref_mem[ref_sp] = p[15:0]; ref_sp = (ref_sp + 4095) % 4096; lat = 3; wes = 2;
      end
      3'd6: begin
        ref_sp = (ref_sp + 1) % 4096; pco[15:0] = ref_mem[ref_sp];
        ref_sp = (ref_sp + 1) % 4096; pco[31:16] = ref_mem[ref_sp]; pcv = 1; lat = 4;
      end
      default: ;
    endcase
  endtask

  // Drives one accept (caller is at a negedge) and observes until out_valid, bounded
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, r, input logic [31:0] p,
                        input logic [15:0] w, output int lat, output int stalls, output int wes,
                        output logic both, output logic [11:0] wa, output logic [15:0] wd,
                        output logic [11:0] ra);
    logic seen_w, seen_r;
    seen_w = 0; seen_r = 0; lat = -1; stalls = 0; wes = 0; both = 0; wa = 0; wd = 0; ra = 0;
    in_valid = 1; m_op = op; alu_in = a; rdst_in = r; pc_in = p; wb_in = w;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      in_valid = 0;
      if (stall) stalls++;
      if (dmem_we) wes++;
      if (dmem_we && dmem_re) both = 1;
      if (dmem_we && !seen_w) begin seen_w = 1; wa = dmem_addr; wd = dmem_wdata; end
      if (dmem_re && !seen_r) begin seen_r = 1; ra = dmem_addr; end
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic apply_reset();
    in_valid = 0; rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; ref_sp = 4095;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({stall, out_valid, pc_valid, dmem_we, dmem_re} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {stall, out_valid, pc_valid, dmem_we, dmem_re}); end
    checks++; if (sp_out !== 16'h0FFF) begin errors++; $display("FAIL reset_sp: got %h expected 0fff", sp_out); end
    checks++; if ({mem_result, alu_out, wb_out, pc_out, dmem_addr, dmem_wdata} !== '0) begin errors++;
      $display("FAIL reset_data: got %h %h %h %h %h %h expected all zero", mem_result, alu_out, wb_out, pc_out, dmem_addr, dmem_wdata); end
  endtask

  task automatic test_store_load();
    int lat, st, wes, elat, ewes; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    model(3'd2, 16'h0005, 16'h1234, 0, res, pco, pcv, elat, ewes);
    run_op(3'd2, 16'h0005, 16'h1234, 0, 16'h00A1, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 2 || wes !== 1) begin errors++; $display("FAIL store_lat: lat %0d we %0d expected 2/1", lat, wes); end
    checks++; if (wa !== 12'h005 || wd !== 16'h1234) begin errors++; $display("FAIL store_wr: got %h/%h expected 005/1234", wa, wd); end
    checks++; if (mem[5] !== 16'h1234) begin errors++; $display("FAIL store_mem: got %h expected 1234", mem[5]); end
    model(3'd1, 16'h0005, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd1, 16'h0005, 16'h0, 0, 16'h00B2, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 3 || st !== 2) begin errors++; $display("FAIL load_lat: lat %0d stall %0d expected 3/2", lat, st); end
    checks++; if (mem_result !== 16'h1234 || ra !== 12'h005) begin errors++; $display("FAIL load_data: got %h@%h expected 1234@005", mem_result, ra); end
    checks++; if (alu_out !== 16'h0005 || wb_out !== 16'h00B2) begin errors++; $display("FAIL load_pass: got %h/%h expected 0005/00b2", alu_out, wb_out); end
  endtask

  task automatic test_push_pop();
    int lat, st, wes, elat, ewes; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    apply_reset();
    model(3'd3, 0, 16'hAAAA, 0, res, pco, pcv, elat, ewes);
    run_op(3'd3, 16'h0, 16'hAAAA, 0, 16'h1, lat, st, wes, both, wa, wd, ra);
    checks++; if (wa !== 12'hFFF || wd !== 16'hAAAA || lat !== 2) begin errors++; $display("FAIL push: got %h/%h lat %0d expected fff/aaaa lat 2", wa, wd, lat); end
    checks++; if (sp_out !== 16'h0FFE) begin errors++; $display("FAIL push_sp: got %h expected 0ffe", sp_out); end
    model(3'd4, 0, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd4, 16'h0, 16'h0, 0, 16'h2, lat, st, wes, both, wa, wd, ra);
    checks++; if (ra !== 12'hFFF || mem_result !== 16'hAAAA || lat !== 3) begin errors++; $display("FAIL pop: got %h@%h lat %0d expected aaaa@fff lat 3", mem_result, ra, lat); end
    checks++; if (sp_out !== 16'h0FFF) begin errors++; $display("FAIL pop_sp: got %h expected 0fff", sp_out); end
  endtask

  task automatic test_push32_pop32();
    int lat, st, wes, elat, ewes; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    apply_reset();
    model(3'd5, 0, 0, 32'h0001_0200, res, pco, pcv, elat, ewes);
    run_op(3'd5, 16'h0, 16'h0, 32'h0001_0200, 16'h3, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 3 || wes !== 2 || both) begin errors++; $display("FAIL push32_lat: lat %0d we %0d expected 3/2", lat, wes); end
    checks++; if (mem[12'hFFF] !== 16'h0001 || mem[12'hFFE] !== 16'h0200) begin errors++;
      $display("FAIL push32_mem: got %h %h expected 0001 0200", mem[12'hFFF], mem[12'hFFE]); end
    model(3'd6, 0, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd6, 16'h0, 16'h0, 0, 16'h4, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 4 || pc_valid !== 1'b1 || pc_out !== 32'h0001_0200) begin errors++;
      $display("FAIL pop32: lat %0d pcv %b pc %h expected 4/1/00010200", lat, pc_valid, pc_out); end
    checks++; if (sp_out !== 16'h0FFF || mem_result !== 16'h0) begin errors++; $display("FAIL pop32_sp: sp %h res %h expected 0fff/0000", sp_out, mem_result); end
    @(negedge clk);
    checks++; if (pc_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL pop32_pulse: pcv %b ov %b expected 0/0", pc_valid, out_valid); end
  endtask

  task automatic test_sp_wrap();
    int lat, st, wes, elat, ewes; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    apply_reset();
    model(3'd4, 0, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd4, 16'h0, 16'h0, 0, 16'h5, lat, st, wes, both, wa, wd, ra);
    checks++; if (ra !== 12'h000 || sp_out !== 16'h0000 || mem_result !== res) begin errors++;
      $display("FAIL wrap_pop: addr %h sp %h res %h expected 000/0000/%h", ra, sp_out, mem_result, res); end
    model(3'd3, 0, 16'hBEEF, 0, res, pco, pcv, elat, ewes);
    run_op(3'd3, 16'h0, 16'hBEEF, 0, 16'h6, lat, st, wes, both, wa, wd, ra);
    checks++; if (wa !== 12'h000 || sp_out !== 16'h0FFF || mem[0] !== 16'hBEEF) begin errors++;
      $display("FAIL wrap_push: addr %h sp %h mem %h expected 000/0fff/beef", wa, sp_out, mem[0]); end
  endtask

  task automatic test_back_to_back();
    int lat, st, wes, elat, ewes, extra; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    logic [15:0] keep;
    model(3'd0, 0, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd0, 16'h1111, 16'h0, 0, 16'hA001, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 1 || alu_out !== 16'h1111 || wb_out !== 16'hA001) begin errors++; $display("FAIL b2b_0: lat %0d %h/%h expected 1 1111/a001", lat, alu_out, wb_out); end
    model(3'd2, 16'h0321, 16'h4242, 0, res, pco, pcv, elat, ewes);
    run_op(3'd2, 16'h0321, 16'h4242, 0, 16'hA002, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 2 || alu_out !== 16'h0321 || wb_out !== 16'hA002) begin errors++; $display("FAIL b2b_1: lat %0d %h/%h expected 2 0321/a002", lat, alu_out, wb_out); end
    model(3'd7, 0, 0, 0, res, pco, pcv, elat, ewes);
    run_op(3'd7, 16'h3333, 16'h0, 0, 16'hA003, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 1 || alu_out !== 16'h3333 || wb_out !== 16'hA003 || mem_result !== 0) begin errors++; $display("FAIL b2b_2: lat %0d %h/%h expected 1 3333/a003", lat, alu_out, wb_out); end
    keep = ref_mem[12'h123];
    model(3'd1, 16'h0321, 0, 0, res, pco, pcv, elat, ewes);
    in_valid = 1; m_op = 3'd1; alu_in = 16'h0321; wb_in = 16'hA004;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      m_op = 3'd2; alu_in = 16'h0123; rdst_in = ~keep;
      if (out_valid) begin lat = c; break; end
    end
    in_valid = 0;
    checks++; if (lat !== 3 || mem_result !== 16'h4242) begin errors++; $display("FAIL stall_load: lat %0d res %h expected 3/4242", lat, mem_result); end
    extra = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (out_valid || dmem_we) extra++; end
    checks++; if (extra !== 0 || mem[12'h123] !== keep) begin errors++; $display("FAIL stall_ignore: extra %0d mem %h expected 0/%h", extra, mem[12'h123], keep); end
  endtask

  task automatic test_reset_mid();
    int lat, st, wes, elat, ewes; logic both, pcv; logic [11:0] wa, ra; logic [15:0] wd, res; logic [31:0] pco;
    apply_reset();
    in_valid = 1; m_op = 3'd6;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    rst = 1; #1;
    checks++; if (sp_out !== 16'h0FFF || {stall, out_valid, dmem_we, dmem_re} !== 4'b0) begin errors++;
      $display("FAIL reset_mid: sp %h ctrl %b expected 0fff/0000", sp_out, {stall, out_valid, dmem_we, dmem_re}); end
    @(negedge clk); rst = 0; ref_sp = 4095;
    model(3'd3, 0, 16'h7777, 0, res, pco, pcv, elat, ewes);
    run_op(3'd3, 16'h0, 16'h7777, 0, 16'h7, lat, st, wes, both, wa, wd, ra);
    checks++; if (lat !== 2 || wa !== 12'hFFF || sp_out !== 16'h0FFE) begin errors++; $display("FAIL reset_mid_next: lat %0d addr %h sp %h expected 2/fff/0ffe", lat, wa, sp_out); end
  endtask

  task automatic test_random();
    int lat, st, wes, elat, ewes, bad; logic both, epcv; logic [11:0] wa, ra; logic [15:0] wd, eres, a, r, w;
    logic [31:0] epc, p; logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); r = 16'($urandom); p = $urandom; w = 16'($urandom);
      model(op, a, r, p, eres, epc, epcv, elat, ewes);
      run_op(op, a, r, p, w, lat, st, wes, both, wa, wd, ra);
      checks++; if (lat !== elat || st !== elat - 1) begin errors++; $display("FAIL rnd_lat op%0d: lat %0d stall %0d expected %0d/%0d", op, lat, st, elat, elat - 1); end
      checks++; if (mem_result !== eres) begin errors++; $display("FAIL rnd_res op%0d: got %h expected %h", op, mem_result, eres); end
      checks++; if (alu_out !== a || wb_out !== w) begin errors++; $display("FAIL rnd_pass op%0d: got %h/%h expected %h/%h", op, alu_out, wb_out, a, w); end
      checks++; if (sp_out !== 16'(ref_sp)) begin errors++; $display("FAIL rnd_sp op%0d: got %h expected %h", op, sp_out, 16'(ref_sp)); end
      checks++; if (pc_valid !== epcv || (epcv && pc_out !== epc)) begin errors++; $display("FAIL rnd_pc op%0d: got %b/%h expected %b/%h", op, pc_valid, pc_out, epcv, epc); end
      checks++; if (wes !== ewes || both) begin errors++; $display("FAIL rnd_we op%0d: writes %0d both %b expected %0d/0", op, wes, both, ewes); end
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL mem_image: %0d differing words expected 0", bad); end
  endtask

  initial begin
    rst = 1; in_valid = 0; m_op = 0; alu_in = 0; rdst_in = 0; pc_in = 0; wb_in = 0;
    for (int i = 0; i < 4096; i++) begin mem[i] = 16'($urandom); ref_mem[i] = mem[i]; end
    test_reset();
    test_store_load();
    test_push_pop();
    test_push32_pop32();
    test_sp_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Fourth pipeline stage; consumes the Execute stage's ALU result, source operand and control, and performs data-memory access. Owns the stack pointer, which it exports back to Execute as the SP operand. Sequences single-word loads/stores/push/pop and two-word PC push/pop (CALL/RET/INT/RTI) against a synchronous single-port data memory. Stalls upstream while multi-cycle accesses are in flight and presents a registered result to the Write-Back stage.

Parameters:
ADDR_W, 12, data-memory address width (words)
SP_INIT, 2**ADDR_W-1, stack pointer value after reset
WB_W, 16, width of the write-back control bundle passed through

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction present from Execute
m_op  in  3  000 none, 001 load, 010 store, 011 push, 100 pop, 101 push32, 110 pop32, 111 treated as none
alu_in  in  16  ALU_Result from Execute; load/store address = alu_in[ADDR_W-1:0]
rdst_in  in  16  store/push data
pc_in  in  32  PC for push32
wb_in  in  WB_W  write-back control, passed through
stall  out  1  upstream must hold its outputs
dmem_addr  out  ADDR_W  memory address
dmem_wdata  out  16  memory write data
dmem_we  out  1  write enable
dmem_re  out  1  read enable; dmem_rdata valid next cycle
dmem_rdata  in  16  memory read data
sp_out  out  16  current SP, zero-extended (feeds Execute SP_Low)
out_valid  out  1  one-cycle result strobe to Write-Back
mem_result  out  16  read data for load/pop, else 0
alu_out  out  16  latched alu_in (forwarding path)
wb_out  out  WB_W  latched wb_in
pc_out  out  32  popped PC
pc_valid  out  1  pc_out valid (pop32 completion only)

Behaviour:
- Reset: state IDLE; SP=SP_INIT; stall, out_valid, pc_valid, dmem_we, dmem_re = 0; mem_result, alu_out, wb_out, pc_out, dmem_addr, dmem_wdata = 0. Reset mid-operation aborts; no further writes; completed writes stand.
- All outputs registered. State drives the dmem signals.
- States: IDLE, A1, A2, RD, DONE. stall=1 in A1/A2/RD, else 0.
- Accept: in IDLE or DONE with in_valid=1, latch m_op, alu_in, rdst_in, pc_in, wb_in. Op none -> DONE; else -> A1. in_valid ignored while stall=1.
- A1: load: re, addr=alu -> RD. store: we, addr=alu, wdata=rdst -> DONE. push: we at SP, wdata=rdst, SP-=1 -> DONE. pop: SP+=1, re at new SP -> RD. push32: we at SP, wdata=pc[31:16], SP-=1 -> A2. pop32: SP+=1, re at new SP (lo word) -> A2.
- A2: push32: we at SP, wdata=pc[15:0], SP-=1 -> DONE. pop32: capture lo word; SP+=1, re at new SP (hi word) -> RD.
- RD: capture dmem_rdata -> DONE.
- DONE: out_valid=1 for exactly one cycle. alu_out and wb_out are the latched values. mem_result = read word for load/pop, 0 otherwise. pop32: pc_out={hi,lo}, pc_valid=1. Next state: A1/DONE on accept, else IDLE.
- Latency, accept to out_valid: none 1; store/push 2; load/pop/push32 3; pop32 4 cycles. Back-to-back accepts from DONE add no bubble.
- SP arithmetic is modulo 2^ADDR_W: push at 0 wraps to 2^ADDR_W-1; pop at 2^ADDR_W-1 wraps to 0. No overflow flag.
- push32 stores the hi word at the higher address. pop32 returns the lo word from SP+1 and the hi word from SP+2.
- dmem_we and dmem_re are never both 1. Both are 0 in IDLE, DONE and RD.

Test Plan:
- Reset mid pop32 (assert rst in A2) -> SP=0x0FFF, stall=0, out_valid=0, no dmem_we; next accept proceeds normally.
- Store alu_in=0x0005, rdst_in=0x1234, then load alu_in=0x0005 -> dmem_we with addr 5, data 0x1234; load out_valid 3 cycles after accept with mem_result=0x1234; stall high for 2 cycles.
- From reset, push 0xAAAA then pop -> write at 0xFFF, sp_out=0x0FFE; pop reads 0xFFF, mem_result=0xAAAA, sp_out=0x0FFF.
- push32 pc_in=0x0001_0200, then pop32 -> writes 0x0001@0xFFF and 0x0200@0xFFE; pop32 pc_out=0x00010200, pc_valid=1 exactly 4 cycles after accept; SP returns to 0x0FFF.
- SP wrap: pop from reset -> SP=0x000 with read at addr 0; then push -> write at 0x000, SP=0x0FFF.
- Back-to-back: none, store, none accepted in consecutive non-stalled cycles -> out_valid pulses with correct wb_out/alu_out order; in_valid during stall produces no extra accept.
